clk_divider_prog: RTL and testbench
===================================

# clk_divider_prog

Runtime-programmable clock divider: generates a 50 % duty square wave of frequency CLK_FREQ/(2·N) from CLK_50M, where N is a half-period count loaded at run time. It is the parametrised successor of the fixed 1 Hz divider. It adds a width parameter, a loadable ratio applied glitch-free at period boundaries, a count enable, and an optional one-cycle tick strobe. It sits between the system clock and the frequency meter's gate and scan-timing logic.

## Interface

Parameters:
- WIDTH, 25: half-period counter/ratio width; 2^WIDTH must exceed the largest N used.
- DEFAULT_HALF, 25000000: N after reset (1 Hz at 50 MHz); must be less than 2^WIDTH.

Ports:
- CLK_50M  input  1  system clock, 50 MHz, rising edge.
- nCLR  input  1  reset, asynchronous, active-low.
- EN  input  1  count enable; low freezes counter and output.
- LOAD  input  1  one-cycle strobe; captures DIV_HALF into shadow register.
- DIV_HALF  input  WIDTH  requested half-period N in CLK_50M cycles.
- CLK_Out  output  1  divided square wave, registered.
- TICK  output  1  one-cycle pulse coincident with each CLK_Out rising edge.
- PENDING  output  1  high while a loaded ratio awaits commit.

## Operation

- Internal registers:
  - Count[WIDTH-1:0]
  - active ratio A
  - shadow ratio S
  - PENDING flag
- Reset (nCLR low, asynchronous): Count=0, CLK_Out=0, TICK=0, PENDING=0, A=S=DEFAULT_HALF.
- Zero clamp: DIV_HALF=0 is captured as 1, giving the fastest output, CLK_50M/2 = 25 MHz.
- EN=1, Count < A-1: Count increments; CLK_Out holds.
- EN=1, Count = A-1 (toggle event): Count←0; CLK_Out←~CLK_Out.
- Commit on falling toggle: if CLK_Out is currently 1 and PENDING=1, then A←S and PENDING←0.
  - The ratio therefore changes only at a full-period boundary, after the low phase starts.
  - No runt high pulse is possible.
- EN=0: Count, CLK_Out, A, PENDING all hold; TICK=0; LOAD is still accepted.
- LOAD=1: S←clamp(DIV_HALF), PENDING←1. A later LOAD before commit overwrites S (last write wins).
- LOAD coincident with a commit: commit uses the pre-edge S; the new value is captured into S; PENDING stays 1.
- Count > A-1 cannot occur, because A changes only when Count is reset to 0.
- Arithmetic: Count compare is unsigned WIDTH-bit; A-1 is computed in WIDTH bits (A≥1 guaranteed).

## Timing

- Output period is 2·A CLK_50M cycles, with high and low phases of exactly A cycles each.
- CLK_Out changes one clock after the edge at which Count reaches A-1 (registered output, no combinational path from inputs).
- TICK is high for exactly the cycle following a 0→1 toggle, aligned with CLK_Out's first high cycle.
- PENDING rises on the edge after LOAD and falls on the edge that commits.
- Worst-case commit latency after LOAD is 2·A_old cycles.
- Mid-operation reset: all outputs return to reset values immediately (asynchronously). The first toggle after release occurs at cycle A of counting.

## Configuration

- CLKDIV_TICK_EN defined: TICK logic is present as described.
- CLKDIV_TICK_EN undefined: the TICK port remains but is tied constant 0, and its register is omitted.

## Test plan

- Run with DEFAULT_HALF=4, EN=1, after reset.
  - Required: CLK_Out low 4 cycles, then alternating 4 high / 4 low.
  - Required: TICK pulses once per 8 cycles, coincident with each rise.
- While CLK_Out is high mid-phase with A=4, pulse LOAD with DIV_HALF=2.
  - Required: PENDING rises on the next edge.
  - Required: the current high phase completes at 4 cycles, then PENDING clears.
  - Required: the following phases are 2 cycles each.
- Pulse LOAD with DIV_HALF=0.
  - Required: after commit, CLK_Out toggles every cycle (25 MHz).
  - Required: TICK is high every second cycle.
- Drop EN for 10 cycles at Count=2.
  - Required: CLK_Out, Count and TICK freeze (TICK=0).
  - Required: the toggle resumes exactly 2 cycles after EN returns.
- Assert LOAD=3 on the same edge as a commit of S=5.
  - Required: A becomes 5, S becomes 3, PENDING stays 1.
  - Required: A becomes 3 one period later.
- Assert nCLR mid high phase.
  - Required: CLK_Out=0 and PENDING=0 immediately.
  - Required: A reverts to DEFAULT_HALF.

Source files
------------

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable 50 % duty clock divider.
// Output frequency is CLK_50M / (2 * N), where N is a half-period count.
// A new N is staged with LOAD into a shadow register. It is committed only
// when the output falls, so every high phase uses a single ratio.
// Optional feature macro: CLKDIV_TICK_EN enables the TICK strobe.
// Without it, TICK is tied low and its register is omitted.
module clk_divider_prog #(
   parameter int          WIDTH        = 25,
   parameter int unsigned DEFAULT_HALF = 25000000
) (
   input  logic             CLK_50M,
   input  logic             nCLR,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] DIV_HALF,
   output logic             CLK_Out,
   output logic             TICK,
   output logic             PENDING
);

   localparam logic [WIDTH-1:0] RESET_HALF = WIDTH'(DEFAULT_HALF);

   logic [WIDTH-1:0] countQ, countD;
   logic [WIDTH-1:0] activeQ, activeD;
   logic [WIDTH-1:0] shadowQ, shadowD;
   logic             clkOutQ, clkOutD;
   logic             pendingQ, pendingD;
   logic [WIDTH-1:0] divClamped;
   logic [WIDTH-1:0] lastCount;
   logic             toggle;
   logic             commit;

   // A zero request would stall the counter, so it is promoted to the fastest legal ratio.
   assign divClamped = (DIV_HALF == '0) ? WIDTH'(1) : DIV_HALF;

   // The active ratio is never zero, so this subtraction cannot wrap.
   assign lastCount  = activeQ - WIDTH'(1);
   assign toggle     = EN && (countQ == lastCount);

   // Swap ratios only as the output falls. The next high phase then starts cleanly with the new value.
   assign commit     = toggle && clkOutQ && pendingQ;

   // Next-state logic for the counter, output level, ratios and pending flag.
   always_comb begin
      countD   = countQ;
      clkOutD  = clkOutQ;
      activeD  = activeQ;
      shadowD  = shadowQ;
      pendingD = pendingQ;

      if (EN) begin
         if (toggle) begin
            countD  = '0;
            clkOutD = ~clkOutQ;
         end else begin
            countD  = countQ + WIDTH'(1);
         end
      end

      if (commit) begin
         activeD  = shadowQ;
         pendingD = 1'b0;
      end

      // A load on the commit edge wins the flag back. The commit above has already taken the old shadow.
      if (LOAD) begin
         shadowD  = divClamped;
         pendingD = 1'b1;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK_50M or negedge nCLR) begin
      if (!nCLR) begin
         countQ   <= '0;
         clkOutQ  <= 1'b0;
         activeQ  <= RESET_HALF;
         shadowQ  <= RESET_HALF;
         pendingQ <= 1'b0;
      end else begin
         countQ   <= countD;
         clkOutQ  <= clkOutD;
         activeQ  <= activeD;
         shadowQ  <= shadowD;
         pendingQ <= pendingD;
      end
   end

   assign CLK_Out = clkOutQ;
   assign PENDING = pendingQ;

`ifdef CLKDIV_TICK_EN
   logic tickQ, tickD;

   // A rising toggle is a toggle taken while the output is currently low.
   assign tickD = toggle && !clkOutQ;

   // Register the strobe so it lines up with the first high cycle of CLK_Out.
   always_ff @(posedge CLK_50M or negedge nCLR) begin
      if (!nCLR) begin
         tickQ <= 1'b0;
      end else begin
         tickQ <= tickD;
      end
   end

   assign TICK = tickQ;
`else
   assign TICK = 1'b0;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: scoreboard bench for clk_divider_prog.
// A phase-based reference model predicts the outputs for each clock.
// It tracks the output level, the cycles left in the current phase, and the
// active, shadow and pending ratio state. After each rising edge, the model
// queues the expected outputs. A monitor pops them on the falling edge and compares.
module tb_clk_divider_prog;

   localparam int WIDTH        = 8;
   localparam int DEFAULT_HALF = 4;
`ifdef CLKDIV_TICK_EN
   localparam bit TICK_BUILT = 1'b1;
`else
   localparam bit TICK_BUILT = 1'b0;
`endif

   typedef struct packed {
      logic clk;
      logic tick;
      logic pend;
   } expect_t;

   logic             CLK_50M;
   logic             nCLR;
   logic             EN;
   logic             LOAD;
   logic [WIDTH-1:0] DIV_HALF;
   logic             CLK_Out;
   logic             TICK;
   logic             PENDING;

   int      totalChecks = 0;
   int      passCount   = 0;
   expect_t expQ[$];
   bit      modelValid  = 1'b0;

   bit mLevel;
   bit mTick;
   bit mPending;
   int mPhaseLeft;
   int mActive;
   int mShadow;

   clk_divider_prog #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) dut (
      .CLK_50M  (CLK_50M),
      .nCLR     (nCLR),
      .EN       (EN),
      .LOAD     (LOAD),
      .DIV_HALF (DIV_HALF),
      .CLK_Out  (CLK_Out),
      .TICK     (TICK),
      .PENDING  (PENDING)
   );

   // 50 MHz system clock.
   initial begin
      CLK_50M = 1'b0;
      forever #10 CLK_50M = ~CLK_50M;
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      totalChecks++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
   endtask

   task automatic reportTimeout(input string name);
      totalChecks++;
      $display("[TB] FAIL %s: wait expired, got no matching phase, expected one within bound", name);
   endtask

   function automatic expect_t modelOutputs();
      expect_t e;
      e.clk  = mLevel;
      e.tick = TICK_BUILT ? mTick : 1'b0;
      e.pend = mPending;
      return e;
   endfunction

   // Reference model: a high or low phase lasts mActive enabled cycles. Ratio swaps happen only when a high phase ends.
   always @(posedge CLK_50M or negedge nCLR) begin
      if (!nCLR) begin
         mLevel     = 1'b0;
         mTick      = 1'b0;
         mPending   = 1'b0;
         mActive    = DEFAULT_HALF;
         mShadow    = DEFAULT_HALF;
         mPhaseLeft = DEFAULT_HALF;
         modelValid = 1'b1;
         expQ.delete();
         expQ.push_back(modelOutputs());
      end else if (modelValid) begin
         mTick = 1'b0;
         if (EN) begin
            mPhaseLeft--;
            if (mPhaseLeft == 0) begin
               if (mLevel && mPending) begin
                  mActive  = mShadow;
                  mPending = 1'b0;
               end
               mLevel     = !mLevel;
               mTick      = mLevel;
               mPhaseLeft = mActive;
            end
         end
         if (LOAD) begin
            mShadow  = (DIV_HALF == '0) ? 1 : int'(DIV_HALF);
            mPending = 1'b1;
         end
         expQ.push_back(modelOutputs());
      end
   end

   // Monitor: compare one queued expectation against the DUT per clock, away from the active edge.
   always @(negedge CLK_50M) begin
      expect_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("CLK_Out", CLK_Out, e.clk);
         checkOutput("TICK", TICK, e.tick);
         checkOutput("PENDING", PENDING, e.pend);
      end else if (modelValid) begin
         totalChecks++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry at %0t", $time);
      end
   end

   // Drive one cycle of inputs from a falling edge through the next falling edge.
   task automatic applyStimulus(input bit en, input bit load, input int div);
      EN       = en;
      LOAD     = load;
      DIV_HALF = WIDTH'(div);
      @(negedge CLK_50M);
   endtask

   task automatic runIdle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0, 0);
   endtask

   // Advance until the next edge is the given number of cycles before a phase end.
   task automatic waitForPhase(input bit needHigh, input bit needPending, input int left, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if ((!needHigh || mLevel) && (!needPending || mPending) && mPhaseLeft == left) begin
            found = 1'b1;
            break;
         end
         applyStimulus(1'b1, 1'b0, 0);
      end
      if (!found) reportTimeout(tag);
   endtask

   // Assert reset between edges and check that the outputs clear without waiting for a clock edge.
   task automatic resetDut(input int cycles);
      #2 nCLR = 1'b0;
      #1;
      checkOutput("reset_CLK_Out", CLK_Out, 1'b0);
      checkOutput("reset_PENDING", PENDING, 1'b0);
      checkOutput("reset_TICK", TICK, 1'b0);
      for (int i = 0; i < cycles; i++) @(negedge CLK_50M);
      #2 nCLR = 1'b1;
   endtask

   initial begin
      nCLR     = 1'b1;
      EN       = 1'b0;
      LOAD     = 1'b0;
      DIV_HALF = '0;
      @(negedge CLK_50M);

      $display("[TB] power-on reset, default ratio");
      resetDut(3);
      runIdle(24);

      $display("[TB] load ratio 2 mid high phase");
      waitForPhase(1'b1, 1'b0, 2, "wait_high_mid");
      applyStimulus(1'b1, 1'b1, 2);
      runIdle(16);

      $display("[TB] load ratio 0, clamped to 1");
      applyStimulus(1'b1, 1'b1, 0);
      runIdle(12);

      $display("[TB] enable freeze at count 2");
      applyStimulus(1'b1, 1'b1, 4);
      runIdle(12);
      waitForPhase(1'b0, 1'b0, 2, "wait_count2");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 0);
      runIdle(10);

      $display("[TB] load coincident with commit");
      applyStimulus(1'b1, 1'b1, 5);
      waitForPhase(1'b1, 1'b1, 1, "wait_commit_edge");
      applyStimulus(1'b1, 1'b1, 3);
      runIdle(30);

      $display("[TB] reset mid high phase");
      applyStimulus(1'b1, 1'b1, 2);
      waitForPhase(1'b1, 1'b0, 2, "wait_high_reset");
      resetDut(2);
      runIdle(12);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 199) == 0) resetDut(1);
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                       int'($urandom_range(0, 6)));
      end
      runIdle(4);

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
